spi_master: RTL

//  Parametrised SPI master, successor to the fixed 8-bit, mode-0, write-only SPI block.

---
 rtl/spi_master_pkg.sv | 17 +
 rtl/spi_master_clk_gen.sv | 49 ++++
 rtl/spi_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master.
//   spi_state_e : transfer FSM states
//   MODE_CPOL / MODE_CPHA : bit positions inside the 2-bit {CPOL,CPHA} mode word
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;

endpackage

// File: rtl/spi_master_clk_gen.sv
// SCK timing generator for the SPI master.
// Ports:
//   clk_50m, rst_n : system clock, synchronous active-low reset
//   i_run          : high in SETUP/XFER/HOLD; counters are cleared otherwise
//   i_edge_en      : high in SETUP/XFER, enables SCK edge strobes
//   o_tick         : last cycle of the current half-period
//   o_lead_stb     : SCK leading (odd-numbered) edge happens at this clock edge
//   o_trail_stb    : SCK trailing (even-numbered) edge happens at this clock edge
//   o_last_edge    : the pending edge is edge 2*DATA_W
module spi_clk_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_edge_en,
  output logic o_tick,
  output logic o_lead_stb,
  output logic o_trail_stb,
  output logic o_last_edge
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [EDGE_W-1:0] r_edge;   // number of SCK edges already emitted
  logic              w_edge_stb;

  always_ff @(posedge clk_50m) begin
    if (!rst_n || !i_run) begin
      r_cnt  <= '0;
      r_edge <= '0;
    end else begin
      if (o_tick) r_cnt <= '0;
      else        r_cnt <= r_cnt + 1'b1;
      if (w_edge_stb) r_edge <= r_edge + 1'b1;
    end
  end

  assign o_tick      = i_run && (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_edge_stb  = o_tick && i_edge_en;
  // The pending edge number is r_edge+1, so an even count means an odd (leading) edge.
  assign o_lead_stb  = w_edge_stb && !r_edge[0];
  assign o_trail_stb = w_edge_stb &&  r_edge[0];
  assign o_last_edge = (r_edge == EDGE_W'(2 * DATA_W - 1));

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master: configurable width, divider, CPOL/CPHA per transfer,
// MISO capture and NUM_CS active-low chip selects. All outputs registered.
// Ports:
//   clk_50m, rst_n         : system clock, synchronous active-low reset
//   spi_start              : transfer request, accepted when spi_busy=0
//   spi_data/mode/cs_sel   : TX word, {CPOL,CPHA}, slave select; latched on accept
//   spi_busy, spi_done     : busy level, one-cycle end-of-transfer pulse
//   spi_rdata              : received word, updated with spi_done
//   sck, cs_n, mosi, miso  : SPI bus
module spi_master
  import spi_master_pkg::*;
#(
  parameter int  DATA_W    = 8,
  parameter int  CLK_DIV   = 4,
  parameter int  NUM_CS    = 1,
  parameter int  MSB_FIRST = 1,
  localparam int SEL_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              spi_start,
  input  logic [DATA_W-1:0] spi_data,
  input  logic [1:0]        spi_mode,
  input  logic [SEL_W-1:0]  spi_cs_sel,
  output logic              spi_busy,
  output logic              spi_done,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);

  spi_state_e        r_state, w_next;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_tx, r_rx, r_rdata;
  logic [NUM_CS-1:0] r_cs_n;
  logic              r_sck, r_mosi, r_done, r_busy;
  logic              w_accept, w_run, w_edge_en;
  logic              w_tick, w_lead, w_trail, w_last_edge;
  logic              w_shift_stb, w_sample_stb;

  function automatic logic tx_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // An out-of-range select matches no line, so every cs_n stays high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (SEL_W'(i) == sel) v[i] = 1'b0;
    return v;
  endfunction

  assign w_accept  = spi_start && !r_busy;
  assign w_run     = (r_state == ST_SETUP) || (r_state == ST_XFER) || (r_state == ST_HOLD);
  assign w_edge_en = (r_state == ST_SETUP) || (r_state == ST_XFER);

  spi_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .i_run       (w_run),
    .i_edge_en   (w_edge_en),
    .o_tick      (w_tick),
    .o_lead_stb  (w_lead),
    .o_trail_stb (w_trail),
    .o_last_edge (w_last_edge)
  );

  // CPHA=0 preloads the first bit at accept, so the final trailing edge must not shift.
  assign w_shift_stb  = r_mode[MODE_CPHA] ? w_lead  : (w_trail && !w_last_edge);
  assign w_sample_stb = r_mode[MODE_CPHA] ? w_trail : w_lead;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SETUP;
      ST_SETUP: if (w_tick) w_next = ST_XFER;
      ST_XFER:  if ((w_lead || w_trail) && w_last_edge) w_next = ST_HOLD;
      ST_HOLD:  if (w_tick) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Control and bus outputs
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_mode  <= 2'b00;
      r_sck   <= 1'b0;
      r_cs_n  <= '1;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (r_state == ST_HOLD) && w_tick;
      if (w_accept) begin
        r_mode <= spi_mode;
        r_sck  <= spi_mode[MODE_CPOL];
        r_cs_n <= cs_decode(spi_cs_sel);
        r_mosi <= spi_mode[MODE_CPHA] ? 1'b0 : tx_bit(spi_data);
      end else begin
        if (w_lead || w_trail) r_sck <= ~r_sck;
        if (w_shift_stb) r_mosi <= tx_bit(r_tx);
        if ((r_state == ST_HOLD) && w_tick) begin
          r_cs_n  <= '1;
          r_rdata <= r_rx;
          r_sck   <= r_mode[MODE_CPOL];
        end
        if (r_state == ST_DONE) r_mosi <= 1'b0;
      end
    end
  end

  // Shift registers (data only, no reset)
  always_ff @(posedge clk_50m) begin
    if (w_accept) begin
      r_tx <= spi_mode[MODE_CPHA] ? spi_data : tx_shift(spi_data);
    end else begin
      if (w_shift_stb)  r_tx <= tx_shift(r_tx);
      if (w_sample_stb) r_rx <= rx_shift(r_rx, miso);
    end
  end

  assign spi_busy  = r_busy;
  assign spi_done  = r_done;
  assign spi_rdata = r_rdata;
  assign sck       = r_sck;
  assign cs_n      = r_cs_n;
  assign mosi      = r_mosi;

endmodule
